uart_transmitter: RTL

//   Buffered 8N1 UART transmitter. It is the transmit-side counterpart of uart_receiver and

---
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: 2**FIFO_DEPTH_BITS byte FIFO feeding an LSB-first shift FSM.
// First start bit appears two cycles after a write into an idle block; writes are dropped while ready=0.
module uart_transmitter #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               data,
  input  logic                     write_req,
  output logic                     ready,
  output logic [FIFO_DEPTH_BITS:0] fifo_count,
  output logic                     busy,
  output logic                     tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]              BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_BITS:0]   FULL      = (FIFO_DEPTH_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic [7:0]                 mem_q [DEPTH];

  logic push;
  logic pop;
  logic bit_end;
  logic have_data;

  // ready looks at the count only, so a same-cycle pop never admits a push while full
  assign ready      = (count_q != FULL);
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign tx         = tx_q;
  assign push       = write_req && ready;
  assign have_data  = (count_q != '0);
  assign bit_end    = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_BITS'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_DEPTH_BITS'(1);
    count_d = count_q + (FIFO_DEPTH_BITS+1)'(push) - (FIFO_DEPTH_BITS+1)'(pop);
  end

  // tx_d carries the level of the state/bit being entered so the pin stays a flop output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (have_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

endmodule
